// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans a COLS x ROWS key matrix one column at a time.
// Each key is debounced across consecutive scans, and debounced press/release
// changes are queued as {pressed, key_code} events in a ready/valid FIFO.
// Ports:
//   clk, reset (async, active-low)
//   scan_enable   - run continuous scanning while high
//   row_in        - raw row pins, active-low (pulled up)
//   col_drive     - column pins, active-low one-hot, all ones when idle
//   event_valid / event_ready / event_data - event FIFO head, {pressed, code}
//   key_state     - debounced pressed state, bit col*ROWS+row
//   overflow      - sticky, an event was dropped on a full FIFO
module key_matrix_scanner #(
  parameter int unsigned COLS     = 9,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned SETTLE   = 1000,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned KW       = $clog2(COLS * ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_enable,
  input  logic [ROWS-1:0]        row_in,
  output logic [COLS-1:0]        col_drive,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [KW:0]            event_data,
  output logic [COLS*ROWS-1:0]   key_state,
  output logic                   overflow
);

  localparam int unsigned KEYS = COLS * ROWS;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SW   = $clog2(SETTLE);
  localparam int unsigned PW   = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_COMPARE = 2'd2;
  localparam logic [1:0] S_NEXT    = 2'd3;

  localparam logic [COLS-1:0] COL_ONE = COLS'(1);

  logic [ROWS-1:0]           row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [SW-1:0]             cnt_q, cnt_d;
  logic [ROWS-1:0]           sample_q, sample_d;
  logic [COLS-1:0]           col_drive_q, col_drive_d;
  logic [KEYS-1:0]           stable_q, stable_d;
  logic [KEYS-1:0][2:0]      dcnt_q, dcnt_d;
  logic [DEPTH-1:0][KW:0]    mem_q, mem_d;
  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]               count_q, count_d;
  logic                      valid_q, valid_d;
  logic [KW:0]               head_q, head_d;
  logic                      ovf_q, ovf_d;

  logic                      push, pop, full, accept;
  logic [KW:0]               push_data;
  logic [KW-1:0]             key_idx;

  // Scan sequencer and per-key debounce.
  always_comb begin
    row_s1_d    = row_in;
    row_s2_d    = row_s1_q;
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    col_drive_d = col_drive_q;
    stable_d    = stable_q;
    dcnt_d      = dcnt_q;
    push        = 1'b0;
    push_data   = '0;
    key_idx     = '0;
    case (state_q)
      S_IDLE: begin
        col_drive_d = '1;
        if (scan_enable) begin
          col_drive_d = ~(COL_ONE << col_q);
          cnt_d       = '0;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(SETTLE - 1)) begin
          // Rows are active-low: a low pin means a pressed key.
          sample_d = ~row_s2_q;
          row_d    = '0;
          state_d  = S_COMPARE;
        end
      end
      S_COMPARE: begin
        key_idx = KW'(col_q) * KW'(ROWS) + KW'(row_q);
        if (sample_q[row_q] == stable_q[key_idx]) begin
          dcnt_d[key_idx] = 3'd0;
        end else if (dcnt_q[key_idx] == 3'(DEBOUNCE - 1)) begin
          stable_d[key_idx] = ~stable_q[key_idx];
          dcnt_d[key_idx]   = 3'd0;
          push              = 1'b1;
          push_data         = {~stable_q[key_idx], key_idx};
        end else begin
          dcnt_d[key_idx] = dcnt_q[key_idx] + 3'd1;
        end
        row_d = row_q + RW'(1);
        if (row_q == RW'(ROWS - 1)) state_d = S_NEXT;
      end
      S_NEXT: begin
        col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        if (scan_enable) begin
          col_drive_d = ~(COL_ONE << col_d);
          cnt_d       = '0;
          state_d     = S_SETTLE;
        end else begin
          col_drive_d = '1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        col_drive_d = '1;
        state_d     = S_IDLE;
      end
    endcase
  end

  // Event FIFO; head is registered so event_data comes straight from a flop.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    pop     = valid_q && event_ready;
    full    = (count_q == (PW+1)'(DEPTH));
    accept  = push && (!full || pop);
    if (accept) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + PW'(1);
    end
    if (push && !accept) ovf_d = 1'b1;
    if (pop) rd_d = rd_q + PW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    head_d  = mem_d[rd_d];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      col_drive_q <= '1;
      stable_q    <= '0;
      dcnt_q      <= '0;
      mem_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      col_drive_q <= col_drive_d;
      stable_q    <= stable_d;
      dcnt_q      <= dcnt_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      ovf_q       <= ovf_d;
    end
  end

  assign col_drive   = col_drive_q;
  assign event_valid = valid_q;
  assign event_data  = head_q;
  assign key_state   = stable_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb_key_matrix_scanner: directed bench for key_matrix_scanner with a short
// settle time (column period 25 cycles, scan period 225 cycles). A behavioural
// key matrix pulls rows low for pressed keys in the driven column.
module tb_key_matrix_scanner;

  logic        clk;
  logic        reset;
  logic        scan_enable;
  logic [7:0]  row_in;
  logic [8:0]  col_drive;
  logic        event_valid;
  logic        event_ready;
  logic [7:0]  event_data;
  logic [71:0] key_state;
  logic        overflow;

  logic [71:0] keys;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  d;
  logic [7:0]  exp_codes [8];

  key_matrix_scanner #(
    .COLS(9), .ROWS(8), .SETTLE(16), .DEBOUNCE(3), .DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .scan_enable(scan_enable), .row_in(row_in),
    .col_drive(col_drive), .event_valid(event_valid), .event_ready(event_ready),
    .event_data(event_data), .key_state(key_state), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a row reads low if any pressed key in a low column is on it.
  always_comb begin
    row_in = '1;
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 8; r++)
        if (!col_drive[c] && keys[c*8 + r]) row_in[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; pops one event and returns its data.
  task automatic pop_event(output logic [7:0] data);
    int n;
    n = 0;
    while (!event_valid && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!event_valid) begin
      chk("pop_timeout", 72'(event_valid), 72'd1);
      data = '0;
    end else begin
      data = event_data;
      event_ready = 1'b1;
      @(negedge clk);
      event_ready = 1'b0;
    end
  endtask

  // Returns at the first negedge of a new scan (column 0 just driven).
  task automatic wait_scan_start();
    logic [8:0] prev;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      prev = col_drive;
      @(negedge clk);
      if (col_drive == 9'h1FE && prev != 9'h1FE) seen = 1'b1;
    end
    chk("scan_align", 72'(seen), 72'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    scan_enable = 1'b1;
    event_ready = 1'b0;
    keys        = '0;
    repeat (3) @(negedge clk);
    chk("rst_col_drive", 72'(col_drive), 72'h1FF);
    chk("rst_valid", 72'(event_valid), 72'd0);
    chk("rst_overflow", 72'(overflow), 72'd0);
    chk("rst_key_state", key_state, 72'd0);

    // First column is driven one cycle after IDLE sees scan_enable.
    reset = 1'b1;
    @(negedge clk);
    chk("first_col", 72'(col_drive), 72'h1FE);

    // Press col 2 row 3 (key 19) for three scans.
    keys[19] = 1'b1;
    repeat (450) @(negedge clk);
    chk("press_2scans", 72'(key_state[19]), 72'd0);
    chk("press_2scans_valid", 72'(event_valid), 72'd0);
    repeat (225) @(negedge clk);
    chk("press_state", key_state, 72'h8_0000);
    chk("press_valid", 72'(event_valid), 72'd1);
    pop_event(d);
    chk("press_code", 72'(d), 72'h93);
    chk("press_single", 72'(event_valid), 72'd0);

    // Release for three scans.
    wait_scan_start();
    keys[19] = 1'b0;
    repeat (450) @(negedge clk);
    chk("release_2scans", 72'(key_state[19]), 72'd1);
    repeat (225) @(negedge clk);
    chk("release_state", key_state, 72'd0);
    pop_event(d);
    chk("release_code", 72'(d), 72'h13);
    chk("release_single", 72'(event_valid), 72'd0);

    // Bounce: 2 pressed, 1 released, 2 pressed, 1 released -> nothing.
    wait_scan_start();
    keys[19] = 1'b1;
    repeat (450) @(negedge clk);
    keys[19] = 1'b0;
    repeat (225) @(negedge clk);
    keys[19] = 1'b1;
    repeat (450) @(negedge clk);
    keys[19] = 1'b0;
    repeat (225) @(negedge clk);
    chk("bounce_valid", 72'(event_valid), 72'd0);
    chk("bounce_state", key_state, 72'd0);

    // Overflow: nine presses in one scan with the consumer stalled.
    keys[8:0] = 9'h1FF;
    repeat (675) @(negedge clk);
    chk("ovf_flag", 72'(overflow), 72'd1);
    chk("ovf_valid", 72'(event_valid), 72'd1);
    chk("ovf_state", key_state, 72'h1FF);
    for (int i = 0; i < 8; i++) begin
      pop_event(d);
      chk($sformatf("ovf_drain%0d", i), 72'(d), 72'(8'h80 + 8'(i)));
    end
    chk("ovf_empty", 72'(event_valid), 72'd0);

    // Release everything so the FIFO holds events before the reset.
    keys = '0;
    repeat (705) @(negedge clk);
    chk("pre_rst_valid", 72'(event_valid), 72'd1);
    chk("pre_rst_overflow", 72'(overflow), 72'd1);

    // Reset in the middle of column 3's settle window.
    wait_scan_start();
    repeat (80) @(negedge clk);
    chk("mid_col3", 72'(col_drive), 72'h1F7);
    reset = 1'b0;
    #1;
    chk("mid_rst_col_drive", 72'(col_drive), 72'h1FF);
    chk("mid_rst_valid", 72'(event_valid), 72'd0);
    chk("mid_rst_overflow", 72'(overflow), 72'd0);
    chk("mid_rst_key_state", key_state, 72'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_col0", 72'(col_drive), 72'h1FE);
    chk("post_rst_valid", 72'(event_valid), 72'd0);

    // Full FIFO with a push and pop landing in the same cycle.
    keys[7:0] = 8'hFF;
    keys[9]   = 1'b1;
    repeat (492) @(negedge clk);
    chk("full_valid", 72'(event_valid), 72'd1);
    chk("full_head", 72'(event_data), 72'h80);
    chk("full_overflow_pre", 72'(overflow), 72'd0);
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    chk("full_overflow_post", 72'(overflow), 72'd0);
    chk("full_state", key_state, 72'h2FF);
    exp_codes = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h89};
    for (int i = 0; i < 8; i++) begin
      pop_event(d);
      chk($sformatf("full_drain%0d", i), 72'(d), 72'(exp_codes[i]));
    end
    chk("full_empty", 72'(event_valid), 72'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
